ip_tx_framer: RTL
=================

// Module: ip_tx_framer
// PURPOSE
//  IPv4 transmit framer: prefixes each TCP segment with a 20-byte IPv4 header (5 x 32-bit words) and a computed checksum.
//  Sits between the TCP layer (upstream) and the Ethernet MAC TX (downstream); counterpart of the IP receive path.
//  Both sides are 32-bit valid/ready streams with a last flag; words are big-endian (first byte on [31:24]).
// PARAMETERS
//  TOS          8'h00        type-of-service byte
//  TTL          8'h40        time-to-live byte
//  PROTOCOL     8'h06        protocol byte (TCP)
//  SRC_ADDR     32'hC0A80001 source IPv4 address
//  DST_ADDR     32'hC0A80002 destination IPv4 address
//  IDENT_INIT   16'h0000     identification value of the first packet after reset
//  MAX_PAYLOAD  16'd65515    largest accepted tcp_tx_len (bytes)
// PORTS
//  clk            in   1   clock
//  rst_n          in   1   synchronous, active-low reset
//  tcp_tx_data    in   32  segment word
//  tcp_tx_valid   in   1   segment word valid
//  tcp_tx_last    in   1   final word of segment
//  tcp_tx_len     in   16  segment length in bytes; valid and stable while tcp_tx_valid on the first word
//  tcp_tx_ready   out  1   segment word accepted when valid&&ready
//  eth_tx_data    out  32  IP packet word
//  eth_tx_valid   out  1   IP packet word valid
//  eth_tx_last    out  1   final word of IP packet
//  eth_tx_ready   in   1   downstream accepts when valid&&ready
// BEHAVIOUR
//  Reset: state IDLE; eth_tx_valid=0, eth_tx_last=0, eth_tx_data=0, tcp_tx_ready=0, ident=IDENT_INIT.
//   Mid-packet reset aborts the packet with no trailing beats; upstream must restart at a segment boundary.
//  Output is one register stage: a beat is held stable while eth_tx_valid && !eth_tx_ready.
//  FSM:
//   IDLE: tcp_tx_ready=0. On tcp_tx_valid: latch len=tcp_tx_len.
//    If len>MAX_PAYLOAD -> DROP. Else -> CSUM.
//   CSUM (1 cycle): total=len+20 (16-bit). Sum all ten header 16-bit halfwords (checksum field=0) in 20-bit accumulator.
//    Fold carries twice, then invert -> csum. Go to HDR with word index 0.
//   HDR: emit W0..W4, one per output handshake; tcp_tx_ready=0. Go to PAY after W4 is loaded.
//    W0={4'h4,4'h5,TOS,total}  W1={ident,16'h4000 (DF set, offset 0)}
//    W2={TTL,PROTOCOL,csum}    W3=SRC_ADDR  W4=DST_ADDR
//   PAY: tcp_tx_ready = !eth_tx_valid || eth_tx_ready. Accepted words pass through with 1-cycle latency.
//    eth_tx_last=tcp_tx_last. After the last word is accepted: ident<=ident+1 (wraps at 16'hFFFF), then IDLE.
//   DROP: tcp_tx_ready=1; words are discarded until the last word is accepted, then IDLE. ident unchanged.
//    No output beats are produced.
//  eth_tx_last is 0 on all header words; a zero-payload segment still supplies one upstream beat (carries last).
//  Payload word count is not checked against len; tcp_tx_last alone ends the packet.
//  Back-to-back: IDLE may accept the next segment's first word in the cycle after the previous last word.
//   Minimum packet-to-packet overhead: 1 IDLE cycle + 1 CSUM cycle.
// CONFIGURATION
//  IP_TX_STATS_EN defined: adds outputs tx_pkt_count[31:0] and tx_drop_count[31:0], both reset to 0 and wrap on overflow.
//   tx_pkt_count increments when a packet's last word is accepted in PAY.
//   tx_drop_count increments on each IDLE->DROP transition.
//  Not defined: ports and counters are absent; drop behaviour is identical.
// TESTING
//  len=20, 5 payload words, eth_tx_ready=1 -> W0=45000028, W1=00004000, W2=4006B97C, W3=C0A80001, W4=C0A80002,
//   then payload verbatim; last only on word 10.
//  Second identical segment -> W1=00014000, W2=4006B97B.
//  eth_tx_ready toggled 1/0 each cycle -> output identical to above; every word held stable while stalled.
//   No upstream word is lost or duplicated.
//  tcp_tx_len=16'hFFF0 with 3 words -> tcp_tx_ready=1 for all 3 words; zero eth beats; tx_drop_count=1.
//   Next valid segment uses ident unchanged.
//  rst_n low for 1 cycle while in HDR at W2 -> eth_tx_valid=0 next cycle; next segment restarts with W0 and ident=IDENT_INIT.
//  IDENT_INIT=16'hFFFF, two packets -> ident FFFF then 0000; checksums are recomputed correctly for each.

Source files
------------

// File: rtl/ip_tx_framer.sv
// rtl/ip_tx_framer.sv - IPv4 transmit framer: prepends a 20-byte header with checksum to each TCP segment.
// Optional IP_TX_STATS_EN adds tx_pkt_count / tx_drop_count outputs.
module ip_tx_framer #(
  parameter logic [7:0]  TOS         = 8'h00,
  parameter logic [7:0]  TTL         = 8'h40,
  parameter logic [7:0]  PROTOCOL    = 8'h06,
  parameter logic [31:0] SRC_ADDR    = 32'hC0A80001,
  parameter logic [31:0] DST_ADDR    = 32'hC0A80002,
  parameter logic [15:0] IDENT_INIT  = 16'h0000,
  parameter logic [15:0] MAX_PAYLOAD = 16'd65515
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] tcp_tx_data,
  input  logic        tcp_tx_valid,
  input  logic        tcp_tx_last,
  input  logic [15:0] tcp_tx_len,
  output logic        tcp_tx_ready,
  output logic [31:0] eth_tx_data,
  output logic        eth_tx_valid,
  output logic        eth_tx_last,
  input  logic        eth_tx_ready
`ifdef IP_TX_STATS_EN
  ,
  output logic [31:0] tx_pkt_count,
  output logic [31:0] tx_drop_count
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CSUM,
    S_HDR,
    S_PAY,
    S_DROP
  } state_t;

  state_t      state, state_next;
  logic [15:0] len_q;
  logic [15:0] ident_q;
  logic [15:0] csum_q;
  logic [2:0]  idx_q;

  logic        slot_free;
  logic        load;
  logic [31:0] load_data;
  logic        load_last;
  logic        hdr_adv;
  logic        pkt_done;
  logic        drop_start;

  logic [15:0] total;
  logic [31:0] hdr_word;
  logic [19:0] sum_acc;
  logic [19:0] fold1;
  logic [15:0] fold2;

  // The output register can take a new beat when empty or draining this cycle.
  assign slot_free = !eth_tx_valid || eth_tx_ready;
  assign total     = len_q + 16'd20;

  // Ones'-complement header sum with the checksum field taken as zero.
  assign sum_acc = {4'h0, 4'h4, 4'h5, TOS} + {4'h0, total}
                 + {4'h0, ident_q} + 20'h04000
                 + {4'h0, TTL, PROTOCOL}
                 + {4'h0, SRC_ADDR[31:16]} + {4'h0, SRC_ADDR[15:0]}
                 + {4'h0, DST_ADDR[31:16]} + {4'h0, DST_ADDR[15:0]};
  assign fold1 = {4'h0, sum_acc[15:0]} + {16'h0, sum_acc[19:16]};
  assign fold2 = fold1[15:0] + {12'h0, fold1[19:16]};

  always_comb begin
    hdr_word = 32'h0;
    case (idx_q)
      3'd0:    hdr_word = {4'h4, 4'h5, TOS, total};
      3'd1:    hdr_word = {ident_q, 16'h4000};
      3'd2:    hdr_word = {TTL, PROTOCOL, csum_q};
      3'd3:    hdr_word = SRC_ADDR;
      3'd4:    hdr_word = DST_ADDR;
      default: hdr_word = 32'h0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next   = state;
    tcp_tx_ready = 1'b0;
    load         = 1'b0;
    load_data    = 32'h0;
    load_last    = 1'b0;
    hdr_adv      = 1'b0;
    pkt_done     = 1'b0;
    drop_start   = 1'b0;
    case (state)
      S_IDLE: begin
        if (tcp_tx_valid) begin
          if (tcp_tx_len > MAX_PAYLOAD) begin
            state_next = S_DROP;
            drop_start = 1'b1;
          end else begin
            state_next = S_CSUM;
          end
        end
      end
      S_CSUM: state_next = S_HDR;
      S_HDR: begin
        if (slot_free) begin
          load      = 1'b1;
          load_data = hdr_word;
          hdr_adv   = 1'b1;
          if (idx_q == 3'd4) state_next = S_PAY;
        end
      end
      S_PAY: begin
        tcp_tx_ready = slot_free;
        if (slot_free && tcp_tx_valid) begin
          load      = 1'b1;
          load_data = tcp_tx_data;
          load_last = tcp_tx_last;
          if (tcp_tx_last) begin
            pkt_done   = 1'b1;
            state_next = S_IDLE;
          end
        end
      end
      S_DROP: begin
        tcp_tx_ready = 1'b1;
        if (tcp_tx_valid && tcp_tx_last) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      len_q        <= 16'h0;
      ident_q      <= IDENT_INIT;
      csum_q       <= 16'h0;
      idx_q        <= 3'd0;
      eth_tx_data  <= 32'h0;
      eth_tx_valid <= 1'b0;
      eth_tx_last  <= 1'b0;
    end else begin
      if (state == S_IDLE && tcp_tx_valid) len_q <= tcp_tx_len;
      if (state == S_CSUM) begin
        csum_q <= ~fold2;
        idx_q  <= 3'd0;
      end
      if (hdr_adv)  idx_q   <= idx_q + 3'd1;
      if (pkt_done) ident_q <= ident_q + 16'd1;
      if (load) begin
        eth_tx_data  <= load_data;
        eth_tx_valid <= 1'b1;
        eth_tx_last  <= load_last;
      end else if (eth_tx_ready) begin
        eth_tx_valid <= 1'b0;
        eth_tx_last  <= 1'b0;
      end
    end
  end

`ifdef IP_TX_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_pkt_count  <= 32'h0;
      tx_drop_count <= 32'h0;
    end else begin
      if (pkt_done)   tx_pkt_count  <= tx_pkt_count + 32'd1;
      if (drop_start) tx_drop_count <= tx_drop_count + 32'd1;
    end
  end
`endif

endmodule
